// File: rtl/port_rx_sink_pkg.sv
// Shared types and helpers for the egress receiver slice.
package port_rx_sink_pkg;

  localparam int         PACKET_WIDTH = 16;
  localparam int         SEQ_W        = 6;
  localparam logic [1:0] TYPE_RSVD    = 2'b11;

  // Packet layout, MSB first: payload[15:10], type[9:8], target[7:4], source[3:0]
  typedef struct packed {
    logic [SEQ_W-1:0] payload;
    logic [1:0]       typ;
    logic [3:0]       tgt;
    logic [3:0]       src;
  } pkt_t;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01
  } rx_state_e;

  // True when exactly one bit of a 4-bit port mask is set
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Index of the set bit of a one-hot 4-bit mask (caller guarantees one-hot)
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/port_rx_sink_fifo.sv
// First-word-fall-through capture buffer. A pop in the same cycle as a push
// into a full buffer frees the slot first, so the push is accepted (wr_ok).
module rx_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         wr_ok
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_s, pop_s;

  // Status, read-credit arbitration and next-pointer computation
  always_comb begin
    empty    = (cnt_q == {(AW+1){1'b0}});
    full     = (cnt_q == (AW+1)'(DEPTH));
    pop_s    = rd_en && !empty;
    wr_ok    = !full || pop_s;
    push_s   = wr_en && wr_ok;
    wr_ptr_d = push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    rd_data  = empty ? {W{1'b0}} : mem_q[rd_ptr_q];
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since reads are masked while empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/port_rx_sink.sv
// Egress receiver for one switch output port: captures packets into a FWFT
// buffer, checks routing/source/type, keeps saturating per-source and overflow
// counters, sticky error flags and a RUN/HALT capture FSM.
// Optional feature macro: RX_SEQ_CHECK_EN (per-source sequence checking).
module port_rx_sink
  import port_rx_sink_pkg::*;
#(
  parameter int PORT_ID  = 0,
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_out,
  input  logic [PACKET_WIDTH-1:0] pkt_out,
  input  logic                    clr,
  input  logic                    halt_on_err,
  input  logic                    rd_en,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic                    rd_empty,
  output logic [4*CNT_W-1:0]      rx_count,
  output logic [CNT_W-1:0]        ovf_count,
  output logic [3:0]              err_flags,
  output logic [1:0]              state_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0]       OWN_SRC = 4'b0001 << PORT_ID;

  pkt_t                  pkt_s;
  rx_state_e             state_q;
  logic                  take_s, check_s, wr_ok_s, full_s;
  logic                  route_err_s, src_err_s, type_err_s, seq_err_s;
  logic [1:0]            src_idx_s;
  logic [3:0][CNT_W-1:0] rx_count_q, rx_count_d;
  logic [CNT_W-1:0]      ovf_q, ovf_d;
  logic [3:0]            err_q, err_d;

  assign pkt_s   = pkt_t'(pkt_out);
  // HALT ignores the port entirely; clr in the same cycle captures without checking
  assign take_s  = valid_out && (state_q != HALT);
  assign check_s = take_s && !clr;

  rx_capture_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (PACKET_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (take_s),
    .wr_data (pkt_s),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (rd_empty),
    .full    (full_s),
    .wr_ok   (wr_ok_s)
  );

  // Format and routing checks on the incoming packet
  always_comb begin
    route_err_s = (pkt_s.tgt[PORT_ID] == 1'b0);
    src_err_s   = !is_onehot4(pkt_s.src) || (pkt_s.src == OWN_SRC);
    type_err_s  = (pkt_s.typ == TYPE_RSVD);
    src_idx_s   = onehot_idx(pkt_s.src);
  end

`ifdef RX_SEQ_CHECK_EN
  logic [3:0][SEQ_W-1:0] exp_q, exp_d;

  // Per-source expected sequence number; a mismatch flags and resyncs
  always_comb begin
    exp_d     = exp_q;
    seq_err_s = 1'b0;
    if (clr) begin
      exp_d = {(4*SEQ_W){1'b0}};
    end else if (check_s && !src_err_s) begin
      seq_err_s        = (pkt_s.payload != exp_q[src_idx_s]);
      exp_d[src_idx_s] = pkt_s.payload + {{(SEQ_W-1){1'b0}}, 1'b1};
    end else begin
      exp_d = exp_q;
    end
  end

  // Expected-sequence table registers
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= {(4*SEQ_W){1'b0}};
    end else begin
      exp_q <= exp_d;
    end
  end
`else
  assign seq_err_s = 1'b0;
`endif

  // Next values of counters and sticky flags
  always_comb begin
    rx_count_d = rx_count_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    if (clr) begin
      rx_count_d = {(4*CNT_W){1'b0}};
      ovf_d      = {CNT_W{1'b0}};
      err_d      = 4'b0000;
    end else begin
      if (take_s && !wr_ok_s && (ovf_q != CNT_MAX)) begin
        ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ovf_d = ovf_q;
      end
      if (check_s) begin
        err_d = err_q | {seq_err_s, type_err_s, src_err_s, route_err_s};
      end else begin
        err_d = err_q;
      end
      if (check_s && !src_err_s && (rx_count_q[src_idx_s] != CNT_MAX)) begin
        rx_count_d[src_idx_s] = rx_count_q[src_idx_s] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        rx_count_d = rx_count_q;
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count_q <= {(4*CNT_W){1'b0}};
      ovf_q      <= {CNT_W{1'b0}};
      err_q      <= 4'b0000;
    end else begin
      rx_count_q <= rx_count_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  // Capture FSM: halt on any error when enabled, clr resumes; illegal codes recover to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (clr) begin
            state_q <= RUN;
          end else if (halt_on_err && (err_d != 4'b0000)) begin
            state_q <= HALT;
          end else begin
            state_q <= RUN;
          end
        end
        HALT: begin
          if (clr) begin
            state_q <= RUN;
          end else begin
            state_q <= HALT;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign rx_count  = rx_count_q;
  assign ovf_count = ovf_q;
  assign err_flags = err_q;
  assign state_o   = state_q;

endmodule
